prio_encoder_reg: RTL and testbench

- Parametrised, registered priority encoder; successor to the fixed 4-to-2 one-hot encoder.
- Accepts an N-bit request vector with a valid/ready handshake and emits the index of the highest-priority set bit plus a valid flag.
- Optional round-robin mode rotates priority after each grant.
- Sits between request sources (interrupt lines, arbiter requests) and downstream index consumers.

---
 rtl/prio_enc_pkg.sv | 21 ++
 rtl/prio_find_first.sv | 24 ++
 rtl/prio_encoder_reg.sv | 146 ++++++++++++++
 tb/tb_prio_encoder_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered priority encoder.
// Also used by the optional one-hot grant output (PRIO_ENC_ONEHOT_EN).
package prio_enc_pkg;

  typedef enum logic {IDLE, HOLD} prio_state_e;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Rotates the low n bits of v left by amt; bits at or above n come back as zero.
  function automatic logic [63:0] rotate_left(input logic [63:0] v, input int amt, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n) r[(i + amt) % n] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational highest-set-bit finder. The found flag is low for an all-zero vector.
module prio_find_first
  import prio_enc_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = clog2_safe(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_reg.sv
// Registered N-input priority encoder with valid/ready handshake and optional round-robin priority.
// Defining PRIO_ENC_ONEHOT_EN adds a registered one-hot grant output.
module prio_encoder_reg
  import prio_enc_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int RR_MODE = 0,
  localparam int IDX_W   = clog2_safe(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx,
  output logic             none,
  output logic             multi
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [N-1:0]     grant
`endif
);

  prio_state_e      state_q;
  logic [IDX_W-1:0] idx_q;
  logic             none_q;
  logic             multi_q;
  logic             accept;
  logic             drain;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             multi_next;

  assign out_valid  = (state_q == HOLD);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign drain      = out_valid && out_ready;
  assign multi_next = |(req & (req - N'(1)));

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [IDX_W-1:0] rr_ptr;
      logic [IDX_W-1:0] last_grant;
      logic [IDX_W-1:0] search_start;
      logic [N-1:0]     low_mask;
      logic [IDX_W-1:0] m_idx;
      logic [IDX_W-1:0] u_idx;
      logic             m_found;
      logic             u_found;

      // rr_ptr holds the last granted index, so the reset value 0 starts the search at N-1.
      // A result draining this cycle is forwarded so a simultaneous accept sees the new pointer.
      always_comb begin
        last_grant   = (drain && !none_q) ? idx_q : rr_ptr;
        search_start = (last_grant == '0) ? IDX_W'(N - 1) : last_grant - IDX_W'(1);
        low_mask     = '0;
        for (int i = 0; i < N; i++) begin
          low_mask[i] = (i <= int'(search_start));
        end
      end

      prio_find_first #(.N(N)) u_masked (
        .vec   (req & low_mask),
        .idx   (m_idx),
        .found (m_found)
      );

      prio_find_first #(.N(N)) u_unmasked (
        .vec   (req),
        .idx   (u_idx),
        .found (u_found)
      );

      assign sel_idx   = m_found ? m_idx : u_idx;
      assign sel_found = u_found;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rr_ptr <= '0;
        end else if (drain && !none_q) begin
          rr_ptr <= idx_q;
        end
      end
    end else begin : g_fixed
      prio_find_first #(.N(N)) u_find (
        .vec   (req),
        .idx   (sel_idx),
        .found (sel_found)
      );
    end
  endgenerate

`ifdef PRIO_ENC_ONEHOT_EN
  logic [N-1:0] grant_q;
  logic [N-1:0] grant_next;

  assign grant_next = sel_found ? N'(rotate_left(64'd1, int'(sel_idx), N)) : '0;
  assign grant      = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
    end else if (accept) begin
      grant_q <= grant_next;
    end
  end
`endif

  // A new vector loads whenever the output slot is empty or draining; otherwise the result holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= HOLD;
            idx_q   <= sel_idx;
            none_q  <= !sel_found;
            multi_q <= multi_next;
          end
        end
        HOLD: begin
          if (accept) begin
            idx_q   <= sel_idx;
            none_q  <= !sel_found;
            multi_q <= multi_next;
          end else if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idx   = idx_q;
  assign none  = none_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_prio_encoder_reg.sv
// Directed bench: fixed-priority N=8 instance and round-robin N=4 instance sharing clock and reset.
// Grant checks are included when PRIO_ENC_ONEHOT_EN is defined.
module tb_prio_encoder_reg;

  logic       clk;
  logic       rst_n;

  logic       fx_in_valid, fx_in_ready, fx_out_valid, fx_out_ready, fx_none, fx_multi;
  logic [7:0] fx_req;
  logic [2:0] fx_idx;

  logic       rr_in_valid, rr_in_ready, rr_out_valid, rr_out_ready, rr_none, rr_multi;
  logic [3:0] rr_req;
  logic [1:0] rr_idx;

`ifdef PRIO_ENC_ONEHOT_EN
  logic [7:0] fx_grant;
  logic [3:0] rr_grant;
`endif

  int errors = 0;
  int checks = 0;

  prio_encoder_reg #(.N(8), .RR_MODE(0)) dut_fix (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fx_in_valid),
    .in_ready  (fx_in_ready),
    .req       (fx_req),
    .out_valid (fx_out_valid),
    .out_ready (fx_out_ready),
    .idx       (fx_idx),
    .none      (fx_none),
    .multi     (fx_multi)
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    .grant     (fx_grant)
`endif
  );

  prio_encoder_reg #(.N(4), .RR_MODE(1)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rr_in_valid),
    .in_ready  (rr_in_ready),
    .req       (rr_req),
    .out_valid (rr_out_valid),
    .out_ready (rr_out_ready),
    .idx       (rr_idx),
    .none      (rr_none),
    .multi     (rr_multi)
`ifdef PRIO_ENC_ONEHOT_EN
    ,
    .grant     (rr_grant)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fx_in_valid = 1'b0; fx_req = '0; fx_out_ready = 1'b0;
    rr_in_valid = 1'b0; rr_req = '0; rr_out_ready = 1'b0;
    #3;
    checks++; if (fx_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", fx_out_valid); end
    checks++; if (fx_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_idx got=%0d exp=0", fx_idx); end
    checks++; if (fx_none !== 1'b0) begin errors++; $display("[TB] FAIL reset_none got=%b exp=0", fx_none); end
    checks++; if (fx_multi !== 1'b0) begin errors++; $display("[TB] FAIL reset_multi got=%b exp=0", fx_multi); end
    checks++; if (fx_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", fx_in_ready); end
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rr_out_valid got=%b exp=0", rr_out_valid); end
`ifdef PRIO_ENC_ONEHOT_EN
    checks++; if (fx_grant !== 8'h00) begin errors++; $display("[TB] FAIL reset_grant got=%h exp=00", fx_grant); end
`endif
    #10;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fixed();
    fx_in_valid = 1'b1; fx_out_ready = 1'b1; fx_req = 8'b0010_0100;
    step();
    checks++; if (fx_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fixed_a_valid got=%b exp=1", fx_out_valid); end
    checks++; if (fx_idx !== 3'd5) begin errors++; $display("[TB] FAIL fixed_a_idx got=%0d exp=5", fx_idx); end
    checks++; if (fx_multi !== 1'b1) begin errors++; $display("[TB] FAIL fixed_a_multi got=%b exp=1", fx_multi); end
    checks++; if (fx_none !== 1'b0) begin errors++; $display("[TB] FAIL fixed_a_none got=%b exp=0", fx_none); end
    fx_req = 8'b1000_0001;
    step();
    checks++; if (fx_idx !== 3'd7) begin errors++; $display("[TB] FAIL fixed_b_idx got=%0d exp=7", fx_idx); end
    checks++; if (fx_multi !== 1'b1) begin errors++; $display("[TB] FAIL fixed_b_multi got=%b exp=1", fx_multi); end
    fx_req = 8'b0001_0000;
    step();
    checks++; if (fx_idx !== 3'd4) begin errors++; $display("[TB] FAIL fixed_c_idx got=%0d exp=4", fx_idx); end
    checks++; if (fx_multi !== 1'b0) begin errors++; $display("[TB] FAIL fixed_c_multi got=%b exp=0", fx_multi); end
    fx_in_valid = 1'b0;
    step();
    checks++; if (fx_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fixed_drain_valid got=%b exp=0", fx_out_valid); end
  endtask

  task automatic test_zero();
    fx_in_valid = 1'b1; fx_out_ready = 1'b1; fx_req = 8'h00;
    step();
    checks++; if (fx_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid got=%b exp=1", fx_out_valid); end
    checks++; if (fx_none !== 1'b1) begin errors++; $display("[TB] FAIL zero_none got=%b exp=1", fx_none); end
    checks++; if (fx_idx !== 3'd0) begin errors++; $display("[TB] FAIL zero_idx got=%0d exp=0", fx_idx); end
    checks++; if (fx_multi !== 1'b0) begin errors++; $display("[TB] FAIL zero_multi got=%b exp=0", fx_multi); end
    fx_in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    fx_in_valid = 1'b1; fx_out_ready = 1'b1; fx_req = 8'h01;
    step();
    checks++; if (fx_idx !== 3'd0 || fx_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_load got idx=%0d valid=%b exp idx=0 valid=1", fx_idx, fx_out_valid); end
    fx_out_ready = 1'b0; fx_req = 8'h80;
    #1;
    checks++; if (fx_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got=%b exp=0", fx_in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (fx_idx !== 3'd0 || fx_out_valid !== 1'b1 || fx_none !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d got idx=%0d valid=%b none=%b exp idx=0 valid=1 none=0", c, fx_idx, fx_out_valid, fx_none); end
    end
    fx_out_ready = 1'b1;
    step();
    checks++; if (fx_idx !== 3'd7 || fx_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got idx=%0d valid=%b exp idx=7 valid=1", fx_idx, fx_out_valid); end
    fx_in_valid = 1'b0;
    step();
  endtask

`ifdef PRIO_ENC_ONEHOT_EN
  task automatic test_onehot();
    fx_in_valid = 1'b1; fx_out_ready = 1'b1; fx_req = 8'b0100_1000;
    step();
    checks++; if (fx_grant !== 8'b0100_0000) begin errors++; $display("[TB] FAIL onehot_grant got=%b exp=01000000", fx_grant); end
    fx_req = 8'h00;
    step();
    checks++; if (fx_grant !== 8'h00) begin errors++; $display("[TB] FAIL onehot_zero got=%b exp=00000000", fx_grant); end
    fx_in_valid = 1'b0;
    step();
  endtask
`endif

  task automatic test_round_robin();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    rr_in_valid = 1'b1; rr_out_ready = 1'b1; rr_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (rr_idx !== exp_seq[k] || rr_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_seq%0d got idx=%0d valid=%b exp idx=%0d valid=1", k, rr_idx, rr_out_valid, exp_seq[k]); end
    end
    rr_req = 4'b0000;
    step();
    checks++; if (rr_none !== 1'b1 || rr_idx !== 2'd0) begin errors++; $display("[TB] FAIL rr_zero got none=%b idx=%0d exp none=1 idx=0", rr_none, rr_idx); end
    rr_req = 4'b1111;
    step();
    checks++; if (rr_idx !== 2'd2) begin errors++; $display("[TB] FAIL rr_after_zero got=%0d exp=2", rr_idx); end
    rr_req = 4'b0101;
    step();
    checks++; if (rr_idx !== 2'd0) begin errors++; $display("[TB] FAIL rr_sparse_a got=%0d exp=0", rr_idx); end
    step();
    checks++; if (rr_idx !== 2'd2) begin errors++; $display("[TB] FAIL rr_sparse_wrap got=%0d exp=2", rr_idx); end
    rr_req = 4'b1111;
    step();
    checks++; if (rr_idx !== 2'd1 || rr_multi !== 1'b1) begin errors++; $display("[TB] FAIL rr_pre_reset got idx=%0d multi=%b exp idx=1 multi=1", rr_idx, rr_multi); end
  endtask

  task automatic test_reset_mid_hold();
    rr_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid got=%b exp=0", rr_out_valid); end
    checks++; if (rr_idx !== 2'd0) begin errors++; $display("[TB] FAIL async_reset_idx got=%0d exp=0", rr_idx); end
    #3;
    rst_n = 1'b1;
    rr_in_valid = 1'b1; rr_out_ready = 1'b1; rr_req = 4'b1111;
    step();
    checks++; if (rr_idx !== 2'd3 || rr_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_grant got idx=%0d valid=%b exp idx=3 valid=1", rr_idx, rr_out_valid); end
    rr_in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_zero();
    test_backpressure();
`ifdef PRIO_ENC_ONEHOT_EN
    test_onehot();
`endif
    test_round_robin();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
